// File: rtl/pleasure_pkg.sv
// Shared emotion-stage types and mood encodings.
// Reused by pleasure_level and sibling emotion stages.
package pleasure_pkg;

  typedef logic [1:0] mood_t;

  localparam mood_t MOOD_NEUTRAL    = 2'b00;
  localparam mood_t MOOD_PLEASED    = 2'b01;
  localparam mood_t MOOD_DISPLEASED = 2'b10;

endpackage

// File: rtl/sat_step_counter.sv
// Saturating up/down/toward-MID step register.
// Ports: clk, rst, en_i, inc_i, dec_i, to_mid_i, level_o, changed_o.
module sat_step_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             to_mid_i,
  output logic [WIDTH-1:0] level_o,
  output logic             changed_o
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] MID =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] level_q, level_d;
  logic             changed_q;

  always_comb begin
    level_d = level_q;
    if (en_i) begin
      if (inc_i && !dec_i) begin
        if (level_q != MAX)
          level_d = level_q + 1'b1;
      end else if (dec_i && !inc_i) begin
        if (level_q != '0)
          level_d = level_q - 1'b1;
      end else if (to_mid_i) begin
        if (level_q > MID)
          level_d = level_q - 1'b1;
        else if (level_q < MID)
          level_d = level_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= MID;
      changed_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      changed_q <= (level_d != level_q);
    end
  end

  assign level_o   = level_q;
  assign changed_o = changed_q;

endmodule

// File: rtl/pleasure_level.sv
// Integrates regulator requests into a decaying level + mood.
// Ports: clk, rst, tick, pleasure_inc/dec -> level, mood, flags.
module pleasure_level
  import pleasure_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int LOW_TH      = 4,
  parameter int HIGH_TH     = 12,
  parameter int HYST        = 2,
  parameter int DECAY_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             pleasure_inc,
  input  logic             pleasure_dec,
  output logic [WIDTH-1:0] level,
  output logic [1:0]       mood,
  output logic             level_changed,
  output logic             at_max,
  output logic             at_min
);

  localparam int IW = $clog2(DECAY_TICKS) + 1;
  localparam logic [IW-1:0] IDLE_LAST =
    IW'(DECAY_TICKS - 1);

  localparam logic [WIDTH-1:0] LOW_L   = WIDTH'(LOW_TH);
  localparam logic [WIDTH-1:0] HIGH_L  = WIDTH'(HIGH_TH);
  localparam logic [WIDTH-1:0] P_LEAVE =
    WIDTH'(HIGH_TH - HYST);
  localparam logic [WIDTH-1:0] D_LEAVE =
    WIDTH'(LOW_TH + HYST);

  logic          pend_inc_q, pend_inc_d;
  logic          pend_dec_q, pend_dec_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          inc_e, dec_e, decay;
  mood_t         mood_q, mood_d;

  // Requests seen in the tick cycle itself still count.
  assign inc_e = pend_inc_q | pleasure_inc;
  assign dec_e = pend_dec_q | pleasure_dec;

  assign pend_inc_d = tick ? 1'b0 : inc_e;
  assign pend_dec_d = tick ? 1'b0 : dec_e;

  always_comb begin
    idle_d = idle_q;
    decay  = 1'b0;
    if (tick) begin
      if (inc_e || dec_e) begin
        idle_d = '0;
      end else if (idle_q == IDLE_LAST) begin
        idle_d = '0;
        decay  = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  sat_step_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (tick),
    .inc_i    (inc_e),
    .dec_i    (dec_e),
    .to_mid_i (decay),
    .level_o  (level),
    .changed_o(level_changed)
  );

  always_comb begin
    mood_d = mood_q;
    case (mood_q)
      MOOD_NEUTRAL: begin
        if (level >= HIGH_L)
          mood_d = MOOD_PLEASED;
        else if (level <= LOW_L)
          mood_d = MOOD_DISPLEASED;
      end
      MOOD_PLEASED: begin
        if (level <= LOW_L)
          mood_d = MOOD_DISPLEASED;
        else if (level < P_LEAVE)
          mood_d = MOOD_NEUTRAL;
      end
      MOOD_DISPLEASED: begin
        if (level >= HIGH_L)
          mood_d = MOOD_PLEASED;
        else if (level > D_LEAVE)
          mood_d = MOOD_NEUTRAL;
      end
      default: mood_d = MOOD_NEUTRAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_inc_q <= 1'b0;
      pend_dec_q <= 1'b0;
      idle_q     <= '0;
      mood_q     <= MOOD_NEUTRAL;
    end else begin
      pend_inc_q <= pend_inc_d;
      pend_dec_q <= pend_dec_d;
      idle_q     <= idle_d;
      mood_q     <= mood_d;
    end
  end

  assign mood   = mood_q;
  assign at_max = (level == '1);
  assign at_min = (level == '0);

endmodule

// File: tb/tb_pleasure_level.sv
// Scoreboard bench for pleasure_level.
// Reference model predicts each cycle; DUT sampled 1ns after edge.
module tb_pleasure_level;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       pleasure_inc = 1'b0;
  logic       pleasure_dec = 1'b0;
  logic [3:0] level;
  logic [1:0] mood;
  logic       level_changed;
  logic       at_max;
  logic       at_min;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int lvl;
    int chg;
    int md;
  } exp_t;

  exp_t sb[$];

  int m_lvl, m_md, m_pi, m_pd, m_idle, m_chg;

  always #5 clk = ~clk;

  pleasure_level dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .pleasure_inc (pleasure_inc),
    .pleasure_dec (pleasure_dec),
    .level        (level),
    .mood         (mood),
    .level_changed(level_changed),
    .at_max       (at_max),
    .at_min       (at_min)
  );

  task automatic chk(string tag, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, act, exp);
    end
  endtask

  function automatic int next_mood(int md, int l);
    if (md == 0) begin
      if (l >= 12) return 1;
      if (l <= 4) return 2;
      return 0;
    end else if (md == 1) begin
      if (l <= 4) return 2;
      if (l < 10) return 0;
      return 1;
    end else begin
      if (l >= 12) return 1;
      if (l > 6) return 0;
      return 2;
    end
  endfunction

  task automatic model_reset();
    m_lvl = 8; m_md = 0; m_pi = 0;
    m_pd = 0; m_idle = 0; m_chg = 0;
  endtask

  task automatic model_step(int i, int d, int t);
    int nm, nl, ie, de;
    exp_t e;
    nm = next_mood(m_md, m_lvl);
    nl = m_lvl;
    if (t != 0) begin
      ie = m_pi | i;
      de = m_pd | d;
      m_pi = 0;
      m_pd = 0;
      if (ie != 0 || de != 0) begin
        m_idle = 0;
        if (ie != 0 && de == 0 && nl < 15) nl++;
        if (de != 0 && ie == 0 && nl > 0) nl--;
      end else if (m_idle == 7) begin
        m_idle = 0;
        if (nl > 8) nl--;
        else if (nl < 8) nl++;
      end else begin
        m_idle++;
      end
    end else begin
      m_pi |= i;
      m_pd |= d;
    end
    m_chg = (nl != m_lvl) ? 1 : 0;
    m_lvl = nl;
    m_md = nm;
    e.lvl = m_lvl;
    e.chg = m_chg;
    e.md = m_md;
    sb.push_back(e);
  endtask

  task automatic cyc(int i, int d, int t);
    exp_t e;
    pleasure_inc = i[0];
    pleasure_dec = d[0];
    tick = t[0];
    model_step(i, d, t);
    @(posedge clk);
    #1;
    pleasure_inc = 1'b0;
    pleasure_dec = 1'b0;
    tick = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("level", int'(level), e.lvl);
      chk("changed", int'(level_changed), e.chg);
      chk("mood", int'(mood), e.md);
      chk("at_max", int'(at_max), (e.lvl == 15) ? 1 : 0);
      chk("at_min", int'(at_min), (e.lvl == 0) ? 1 : 0);
    end
  endtask

  task automatic inc_tick();
    cyc(1, 0, 0);
    cyc(0, 0, 1);
  endtask

  task automatic dec_tick();
    cyc(0, 1, 0);
    cyc(0, 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_async_level", int'(level), 8);
    chk("rst_async_mood", int'(mood), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    sb.delete();
    chk("rst_changed", int'(level_changed), 0);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_level", int'(level), 8);
    chk("rst_mood", int'(mood), 0);
    chk("rst_changed", int'(level_changed), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    inc_tick();
    chk("lvl9", int'(level), 9);
    inc_tick();
    chk("lvl10", int'(level), 10);
    inc_tick();
    chk("lvl11", int'(level), 11);
    chk("mood_n", int'(mood), 0);

    inc_tick();
    chk("lvl12", int'(level), 12);
    cyc(0, 0, 0);
    chk("mood_p", int'(mood), 1);
    dec_tick();
    dec_tick();
    cyc(0, 0, 0);
    chk("lvl10_p", int'(level), 10);
    chk("mood_hold_p", int'(mood), 1);
    dec_tick();
    cyc(0, 0, 0);
    chk("mood_back_n", int'(mood), 0);

    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    cyc(0, 0, 1);
    chk("collapse", int'(level), 10);

    cyc(1, 1, 1);
    chk("cancel_lvl", int'(level), 10);
    chk("cancel_chg", int'(level_changed), 0);

    for (int k = 0; k < 7; k++) inc_tick();
    chk("max", int'(level), 15);
    inc_tick();
    inc_tick();
    chk("sat_max", int'(at_max), 1);
    chk("sat_max_chg", int'(level_changed), 0);

    for (int k = 0; k < 17; k++) dec_tick();
    chk("sat_min", int'(at_min), 1);
    chk("sat_min_chg", int'(level_changed), 0);
    chk("mood_d", int'(mood), 2);

    for (int k = 0; k < 11; k++) cyc(1, 0, 1);
    chk("climb11", int'(level), 11);

    cyc(1, 0, 0);
    do_reset();
    cyc(0, 0, 1);
    chk("post_rst_lvl", int'(level), 8);
    chk("post_rst_chg", int'(level_changed), 0);

    for (int k = 0; k < 3; k++) inc_tick();
    for (int k = 0; k < 5; k++) cyc(0, 0, 1);
    cyc(1, 1, 1);
    for (int k = 0; k < 7; k++) cyc(0, 0, 1);
    chk("idle_reset", int'(level), 11);
    cyc(0, 0, 1);
    chk("decay10", int'(level), 10);
    for (int k = 0; k < 24; k++) begin
      cyc(0, 0, 1);
      cyc(0, 0, 0);
    end
    chk("decay_mid", int'(level), 8);
    for (int k = 0; k < 16; k++) cyc(0, 0, 1);
    chk("stay_mid", int'(level), 8);

    for (int k = 0; k < 400; k++) begin
      cyc(int'($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
